// File: rtl/sys_ctrl_alu.sv
// Command controller between the UART receiver/transmitter and the ALU.
// It parses CMD/operand/function byte frames, pulses the ALU enable once per
// operation, captures the ALU result and returns it as two bytes, low byte first.
module sys_ctrl_alu #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [7:0]  CMD_ALU_OP  = 8'hCC,
  parameter logic [7:0]  CMD_ALU_NOP = 8'hDD,
  parameter int          TIMEOUT     = 1000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                RX_P_DATA,
  input  logic                      RX_D_VLD,
  output logic [DATA_WIDTH-1:0]     ALU_A,
  output logic [DATA_WIDTH-1:0]     ALU_B,
  output logic [3:0]                ALU_FUN,
  output logic                      ALU_EN,
  input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                      ALU_OUT_VALID,
  output logic [7:0]                TX_P_DATA,
  output logic                      TX_D_VLD,
  input  logic                      TX_BUSY,
  output logic                      CTRL_BUSY
);

  typedef enum logic [3:0] {
    IDLE,
    GET_A,
    GET_B,
    GET_FUN,
    ALU_RUN,
    ALU_WAIT,
    SEND_LO,
    GAP,
    SEND_HI
  } state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  state_t                    state;
  logic [CNT_W-1:0]          tmo_cnt;
  logic [2*DATA_WIDTH-1:0]   result;

  // Timeout is only meaningful while collecting the bytes of a frame.
  logic in_frame;
  logic tmo_hit;

  // Decode of the frame-collection states and of the idle-limit condition.
  always_comb begin
    in_frame = (state == GET_A) || (state == GET_B) || (state == GET_FUN);
    tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);
  end

  // Single FSM: state, timeout counter, operand/result registers and all
  // registered outputs. CTRL_BUSY is updated together with every state change
  // so it is a clean flop rather than a decode of the multi-bit state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      result    <= '0;
      ALU_A     <= '0;
      ALU_B     <= '0;
      ALU_FUN   <= '0;
      ALU_EN    <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CTRL_BUSY <= 1'b0;
    end else begin
      // Strobes are single-cycle by default.
      ALU_EN   <= 1'b0;
      TX_D_VLD <= 1'b0;

      // The counter clears on any accepted byte or state change and only
      // advances while a frame is waiting for its next byte.
      tmo_cnt <= '0;
      if (in_frame && !RX_D_VLD && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == CMD_ALU_OP) begin
              state     <= GET_A;
              CTRL_BUSY <= 1'b1;
            end else if (RX_P_DATA == CMD_ALU_NOP) begin
              state     <= GET_FUN;
              CTRL_BUSY <= 1'b1;
            end
          end
        end

        GET_A: begin
          if (RX_D_VLD) begin
            ALU_A <= DATA_WIDTH'(RX_P_DATA);
            state <= GET_B;
          end else if (tmo_hit) begin
            state     <= IDLE;
            CTRL_BUSY <= 1'b0;
          end
        end

        GET_B: begin
          if (RX_D_VLD) begin
            ALU_B <= DATA_WIDTH'(RX_P_DATA);
            state <= GET_FUN;
          end else if (tmo_hit) begin
            state     <= IDLE;
            CTRL_BUSY <= 1'b0;
          end
        end

        GET_FUN: begin
          if (RX_D_VLD) begin
            ALU_FUN <= RX_P_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ALU_RUN;
          end else if (tmo_hit) begin
            state     <= IDLE;
            CTRL_BUSY <= 1'b0;
          end
        end

        // ALU_EN is high for exactly this one state.
        ALU_RUN: begin
          state <= ALU_WAIT;
        end

        ALU_WAIT: begin
          if (ALU_OUT_VALID) begin
            result <= ALU_OUT;
            state  <= SEND_LO;
          end
        end

        SEND_LO: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= result[7:0];
            TX_D_VLD  <= 1'b1;
            state     <= GAP;
          end
        end

        // The transmitter's busy flag lags the strobe, so it is not trusted here.
        GAP: begin
          state <= SEND_HI;
        end

        SEND_HI: begin
          if (!TX_BUSY) begin
            TX_P_DATA <= result[15:8];
            TX_D_VLD  <= 1'b1;
            state     <= IDLE;
            CTRL_BUSY <= 1'b0;
          end
        end

        default: begin
          state     <= IDLE;
          CTRL_BUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sys_ctrl_alu.sv
// Directed bench for sys_ctrl_alu: a small registered ALU model and a byte
// monitor surround the controller; expected bytes are hand-computed constants.
module tb_sys_ctrl_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_fun;
  logic        alu_en;
  logic [15:0] alu_out;
  logic        alu_out_valid;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_busy;
  logic        ctrl_busy;

  int checks = 0;
  int errors = 0;

  sys_ctrl_alu dut (
    .clk           (clk),
    .reset         (rst_n),
    .RX_P_DATA     (rx_data),
    .RX_D_VLD      (rx_vld),
    .ALU_A         (alu_a),
    .ALU_B         (alu_b),
    .ALU_FUN       (alu_fun),
    .ALU_EN        (alu_en),
    .ALU_OUT       (alu_out),
    .ALU_OUT_VALID (alu_out_valid),
    .TX_P_DATA     (tx_data),
    .TX_D_VLD      (tx_vld),
    .TX_BUSY       (tx_busy),
    .CTRL_BUSY     (ctrl_busy)
  );

  always #5 clk = ~clk;

  // Registered ALU model: result one cycle after enable unless stalled.
  logic        alu_stall = 1'b0;
  logic        alu_pend;
  logic [15:0] alu_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_pend      <= 1'b0;
      alu_res       <= '0;
      alu_out       <= '0;
      alu_out_valid <= 1'b0;
    end else begin
      alu_out_valid <= 1'b0;
      if (alu_en) begin
        case (alu_fun)
          4'd0:    alu_res <= 16'(alu_a) + 16'(alu_b);
          4'd1:    alu_res <= 16'(alu_a) - 16'(alu_b);
          4'd2:    alu_res <= 16'(alu_a) * 16'(alu_b);
          4'd3:    alu_res <= (alu_b != 0) ? 16'(alu_a / alu_b) : 16'hFFFF;
          default: alu_res <= 16'h0;
        endcase
        alu_pend <= 1'b1;
      end else if (alu_pend && !alu_stall) begin
        alu_out       <= alu_res;
        alu_out_valid <= 1'b1;
        alu_pend      <= 1'b0;
      end
    end
  end

  // Monitor on the falling edge: collects TX bytes and ALU_EN pulses.
  logic [7:0] tx_q[$];
  int         en_cnt  = 0;
  int         en_wide = 0;
  logic       en_prev = 1'b0;
  logic [7:0] en_a, en_b;
  logic [3:0] en_fun;
  always @(negedge clk) begin
    if (tx_vld) tx_q.push_back(tx_data);
    if (alu_en) begin
      en_cnt++;
      en_a   = alu_a;
      en_b   = alu_b;
      en_fun = alu_fun;
      if (en_prev) en_wide++;
    end
    en_prev = alu_en;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_vld  = 1'b1;
    @(negedge clk);
    rx_vld  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (ctrl_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, ctrl_busy}, 32'd0);
  endtask

  // Waits for the frame to finish, then checks the two returned bytes.
  task automatic expect_tx(input string tag, input logic [7:0] lo, input logic [7:0] hi);
    wait_idle(tag);
    repeat (2) @(negedge clk);
    check({tag, "_tx_count"}, tx_q.size(), 32'd2);
    if (tx_q.size() >= 2) begin
      check({tag, "_tx_lo"}, {24'd0, tx_q[0]}, {24'd0, lo});
      check({tag, "_tx_hi"}, {24'd0, tx_q[1]}, {24'd0, hi});
    end
  endtask

  initial begin
    int en0;
    int n;
    rst_n   = 1'b0;
    rx_data = '0;
    rx_vld  = 1'b0;
    tx_busy = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'd0, ctrl_busy}, 32'd0);
    check("rst_en",   {31'd0, alu_en},    32'd0);
    check("rst_txv",  {31'd0, tx_vld},    32'd0);
    check("rst_outs", {alu_a, alu_b, 4'd0, alu_fun, tx_data}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full ADD frame: 5 + 3 = 0x0008
    tx_q.delete();
    en0 = en_cnt;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    expect_tx("add", 8'h08, 8'h00);
    check("add_en_cnt", en_cnt - en0, 32'd1);
    check("add_ops", {8'd0, en_a, en_b, 4'd0, en_fun}, {8'd0, 8'h05, 8'h03, 8'h00});

    // Full MUL frame: FF * FF = 0xFE01
    tx_q.delete();
    send_byte(8'hCC); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    expect_tx("mul", 8'h01, 8'hFE);

    // Full frame then short frame: 0x14 + 0x05 = 0x19, then 0x14 / 0x05 = 4
    tx_q.delete();
    send_byte(8'hCC); send_byte(8'h14); send_byte(8'h05); send_byte(8'h00);
    expect_tx("add2", 8'h19, 8'h00);
    tx_q.delete();
    en0 = en_cnt;
    send_byte(8'hDD); send_byte(8'h03);
    expect_tx("nop", 8'h04, 8'h00);
    check("nop_en_cnt", en_cnt - en0, 32'd1);
    check("nop_ops", {8'd0, en_a, en_b, 4'd0, en_fun}, {8'd0, 8'h14, 8'h05, 8'h03});

    // Garbage bytes in IDLE are ignored
    en0 = en_cnt;
    send_byte(8'h55);
    check("garb_busy_55", {31'd0, ctrl_busy}, 32'd0);
    send_byte(8'hAA);
    check("garb_busy_aa", {31'd0, ctrl_busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("garb_en", en_cnt - en0, 32'd0);

    // Byte injected during ALU_WAIT is dropped: 7 - 2 = 5
    tx_q.delete();
    alu_stall = 1'b1;
    send_byte(8'hCC); send_byte(8'h07); send_byte(8'h02); send_byte(8'h01);
    repeat (3) @(negedge clk);
    send_byte(8'hCC);
    repeat (2) @(negedge clk);
    check("drop_busy", {31'd0, ctrl_busy}, 32'd1);
    alu_stall = 1'b0;
    expect_tx("drop", 8'h05, 8'h00);
    // Next frame after the drop: 9 * 4 = 0x24
    tx_q.delete();
    send_byte(8'hCC); send_byte(8'h09); send_byte(8'h04); send_byte(8'h02);
    expect_tx("after_drop", 8'h24, 8'h00);

    // Timeout: CC,10 then silence; still busy one cycle before expiry
    en0 = en_cnt;
    send_byte(8'hCC); send_byte(8'h10);
    repeat (999) @(negedge clk);
    check("tmo_pre_busy", {31'd0, ctrl_busy}, 32'd1);
    @(negedge clk);
    check("tmo_busy", {31'd0, ctrl_busy}, 32'd0);
    check("tmo_en", en_cnt - en0, 32'd0);
    check("tmo_a_kept", {24'd0, alu_a}, 32'h10);
    tx_q.delete();
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
    expect_tx("tmo_next", 8'h04, 8'h00);

    // Byte arriving in the expiry cycle wins: 6 + 7 = 0x0D
    send_byte(8'hCC);
    repeat (998) @(negedge clk);
    send_byte(8'h06);
    check("edge_busy", {31'd0, ctrl_busy}, 32'd1);
    check("edge_a", {24'd0, alu_a}, 32'h06);
    tx_q.delete();
    send_byte(8'h07); send_byte(8'h00);
    expect_tx("edge", 8'h0D, 8'h00);

    // TX back-pressure: no strobe while busy, then exactly two bytes
    tx_q.delete();
    tx_busy = 1'b1;
    send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
    repeat (55) @(negedge clk);
    check("bp_no_tx", tx_q.size(), 32'd0);
    check("bp_busy", {31'd0, ctrl_busy}, 32'd1);
    tx_busy = 1'b0;
    expect_tx("bp", 8'h08, 8'h00);

    // Reset during GAP: outputs clear at once, no high byte afterwards
    send_byte(8'hCC); send_byte(8'h21); send_byte(8'h12); send_byte(8'h00);
    n = 0;
    while (!tx_vld && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("gap_reached", {31'd0, tx_vld}, 32'd1);
    rst_n = 1'b0;
    #1;
    tx_q.delete();
    check("gap_rst_txv",  {31'd0, tx_vld},    32'd0);
    check("gap_rst_busy", {31'd0, ctrl_busy}, 32'd0);
    check("gap_rst_outs", {alu_a, alu_b, 4'd0, alu_fun, tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("gap_no_hi", tx_q.size(), 32'd0);
    check("gap_idle", {31'd0, ctrl_busy}, 32'd0);

    // Short frame straight after reset uses A = B = 0
    tx_q.delete();
    send_byte(8'hDD); send_byte(8'h00);
    expect_tx("nop_rst", 8'h00, 8'h00);
    check("nop_rst_ops", {8'd0, en_a, en_b, 8'd0}, 32'd0);

    check("en_single_cycle", en_wide, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
